// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: buffers a bundle of random values and turns each one into a timed obstacle spawn.
// Optional `SPAWN_NO_REPEAT_EN bumps a type that would repeat the previous spawn.
module obstacle_scheduler #(
  parameter int NUM_LEN = 3,
  parameter int COUNT = 4,
  parameter int MIN_GAP = 8,
  parameter int GAP_SHIFT = 2,
  parameter int CNT_W = 16,
  localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1
) (
  input logic clock,
  input logic reset,
  input logic enable,
  input logic tick,
  input logic [NUM_LEN*COUNT-1:0] randoms,
  output logic start,
  output logic spawn,
  output logic [NUM_LEN-1:0] spawn_type,
  output logic [IW-1:0] index
);
  typedef enum logic [1:0] {IDLE, REQ, LOAD, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0] index_n;
  logic [NUM_LEN-1:0] vals [COUNT];
  logic [NUM_LEN-1:0] cur, emit, type_n;
  logic spawn_n;
  function automatic logic [CNT_W-1:0] gap(input logic [NUM_LEN-1:0] v);
    return CNT_W'(MIN_GAP) + (CNT_W'(v) << GAP_SHIFT);
  endfunction
  assign start = state == REQ;
  assign cur = vals[index];
`ifdef SPAWN_NO_REPEAT_EN
  logic [NUM_LEN-1:0] prev;
  assign emit = cur == prev ? cur + 1'b1 : cur;
  always_ff @(posedge clock) prev <= !reset ? '0 : spawn_n ? type_n : prev;
`else
  assign emit = cur;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    index_n = index;
    spawn_n = 1'b0;
    type_n = spawn_type;
    case (state)
      IDLE: state_n = enable ? REQ : IDLE;
      REQ: state_n = LOAD;
      LOAD: begin
        index_n = '0;
        cnt_n = gap(randoms[NUM_LEN-1:0]);
        state_n = WAIT;
      end
      default: if (tick && enable) begin
        if (cnt == CNT_W'(1)) begin
          spawn_n = 1'b1;
          type_n = emit;
          if (index == IW'(COUNT - 1)) state_n = REQ;
          else begin
            index_n = index + 1'b1;
            cnt_n = gap(vals[index + 1'b1]);
          end
        end else cnt_n = cnt - 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      index <= '0;
      spawn <= 1'b0;
      spawn_type <= '0;
      for (int i = 0; i < COUNT; i++) vals[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      index <= index_n;
      spawn <= spawn_n;
      spawn_type <= type_n;
      if (state == LOAD) for (int i = 0; i < COUNT; i++) vals[i] <= randoms[i*NUM_LEN +: NUM_LEN];
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed scenarios plus random stimulus against a queue-based reference model.
module tb_obstacle_scheduler;
  localparam int NL = 3, CN = 4;
  logic clock = 0, reset = 0, enable = 0, tick = 0;
  logic [NL*CN-1:0] randoms = '0;
  logic start, spawn;
  logic [NL-1:0] spawn_type;
  logic [1:0] index;
  int errors = 0, checks = 0, cnum = 0;
  int phase = 0, rem = 0, e_idx = 0;
  logic e_spawn = 0;
  logic [NL-1:0] e_type = '0;
  logic [NL-1:0] q[$];
`ifdef SPAWN_NO_REPEAT_EN
  logic [NL-1:0] prev = '0;
`endif

  obstacle_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .tick(tick), .randoms(randoms),
    .start(start), .spawn(spawn), .spawn_type(spawn_type), .index(index)
  );

  always #5 clock = ~clock;

  function automatic int gap(input logic [NL-1:0] v);
    return 8 + 4 * int'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cnum);
    end
  endtask

  // phase: 0 idle, 1 requesting, 2 loading, 3 counting down through the queue
  task automatic model();
    logic [NL-1:0] v;
    e_spawn = 0;
    if (!reset) begin
      phase = 0; q.delete(); rem = 0; e_idx = 0; e_type = '0;
`ifdef SPAWN_NO_REPEAT_EN
      prev = '0;
`endif
    end else if (phase == 0) begin
      if (enable) phase = 1;
    end else if (phase == 1) phase = 2;
    else if (phase == 2) begin
      q.delete();
      for (int i = 0; i < CN; i++) q.push_back(randoms[i*NL +: NL]);
      rem = gap(q[0]); e_idx = 0; phase = 3;
    end else if (enable && tick) begin
      rem--;
      if (rem == 0) begin
        v = q.pop_front();
`ifdef SPAWN_NO_REPEAT_EN
        if (v == prev) v = v + 3'd1;
        prev = v;
`endif
        e_spawn = 1; e_type = v;
        if (q.size() == 0) phase = 1;
        else begin e_idx++; rem = gap(q[0]); end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    cnum++;
    model();
    @(negedge clock);
    chk("start", start, phase == 1);
    chk("spawn", spawn, e_spawn);
    chk("spawn_type", spawn_type, e_type);
    chk("index", index, e_idx);
  endtask

  task automatic restart(input logic [NL*CN-1:0] r);
    reset = 0; enable = 1; tick = 1; randoms = r;
    repeat (3) cyc();
    reset = 1; cnum = 0;
  endtask

  // spawn cycles derived directly from the gap rule: first WAIT is cycle 3
  task automatic bundle(input logic [NL*CN-1:0] r, input logic [NL*CN-1:0] types);
    int c = 3;
    restart(r);
    for (int k = 0; k < CN; k++) begin
      c += gap(r[k*NL +: NL]);
      while (cnum < c) cyc();
      chk("bundle_spawn", spawn, 1);
      chk("bundle_type", spawn_type, types[k*NL +: NL]);
    end
    chk("bundle_refill_start", start, 1);
  endtask

  initial begin
    bundle({3'd5, 3'd0, 3'd2, 3'd1}, {3'd5, 3'd0, 3'd2, 3'd1});
`ifdef SPAWN_NO_REPEAT_EN
    bundle({3'd3, 3'd3, 3'd4, 3'd4}, {3'd4, 3'd3, 3'd5, 3'd4});
`else
    bundle({3'd3, 3'd3, 3'd4, 3'd4}, {3'd3, 3'd3, 3'd4, 3'd4});
`endif
    restart({3'd5, 3'd0, 3'd2, 3'd1});
    while (cnum < 8) cyc();
    enable = 0;
    repeat (20) cyc();
    enable = 1;
    repeat (6) cyc();
    chk("pause_early", spawn, 0);
    cyc();
    chk("pause_spawn", spawn, 1);
    chk("pause_type", spawn_type, 1);
    restart(12'($urandom));
    while (cnum < 300 && index !== 2'd2) cyc();
    chk("reach_idx2", index, 2);
    repeat (3) cyc();
    reset = 0;
    repeat (2) cyc();
    chk("mid_reset_spawn", spawn, 0);
    reset = 1; cnum = 0;
    cyc();
    chk("restart_start", start, 1);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 299) != 0;
      enable = $urandom_range(0, 9) != 0;
      tick = $urandom_range(0, 2) != 0;
      randoms = 12'($urandom);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
